ahb_mem_responder: RTL
======================

Name: ahb_mem_responder

Overview:
- Single-port memory responder on the D1 bus.
- Serves read and write transfers, single or burst, issued by the instruction-fetch cache and other D1 initiators.
- Inserts a parameterised number of wait states per beat.
- Signals errors with a two-cycle error response; the initiator sees it as READYOUT low with RESP high, then both high.
- Sits between the D1 interconnect and on-chip SRAM.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_STATES, 1: stall cycles before each data beat, 0..15.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RSTN  in  1  reset; synchronous, active-low.
- D1_ADDR  in  32  byte address of the first beat.
- D1_WRITE_DATA  in  32  write data, sampled in BEAT.
- D1_READ_DATA  out  32  read data, full word, valid in BEAT.
- D1_WRITE  in  1  1 = write, 0 = read.
- D1_SIZE  in  3  000 byte, 001 half, 010 word; other codes are errors.
- D1_BURST  in  3  000 SINGLE, 001 INCR (open length), 011 INCR4, 101 INCR8, 111 INCR16; other codes are errors.
- D1_READYOUT  out  1  1 = idle/accepting or data beat complete; 0 = stalled.
- D1_RESP  out  1  1 = error response.
- D1_CLAIM  in  1  request valid; for INCR, also holds the burst open.

Behaviour:
- Reset: when RSTN=0 at posedge, state goes to IDLE and outputs become READYOUT=1, RESP=0, READ_DATA=0. Counters clear. Array contents are not reset. Reset mid-burst abandons the burst; any unperformed write beat is dropped.
- States: IDLE, WAIT, BEAT, ERR1, ERR2.
- IDLE
  - Outputs READYOUT=1, RESP=0.
  - A request is sampled only here, when CLAIM=1. The responder latches ADDR, WRITE, SIZE and BURST.
  - Beat count is 1/4/8/16 by burst code; INCR is unbounded.
  - Validity checks on the first beat: legal SIZE, legal BURST, alignment (half: ADDR[0]=0; word: ADDR[1:0]=0), and range (BASE_ADDR <= ADDR < BASE_ADDR+4*DEPTH).
  - Fail -> ERR1. Pass -> WAIT if WAIT_STATES>0, else BEAT.
- WAIT
  - Outputs READYOUT=0, RESP=0.
  - Wait counter loads WAIT_STATES on entry and decrements each cycle; when it reaches 1, next state is BEAT.
  - The array read for the current address is issued so that READ_DATA is registered and valid on entry to BEAT.
- BEAT
  - Outputs READYOUT=1, RESP=0.
  - Read: READ_DATA = mem[word index], full 32-bit word. The initiator selects the lane using ADDR[1:0].
  - Write: WRITE_DATA is sampled this cycle. Byte enables follow SIZE and ADDR[1:0]; only enabled lanes are updated.
  - Next address = current + (1<<SIZE), 32-bit wrap.
  - Fixed burst: remaining beats decrement; at 0 -> IDLE.
  - INCR: continue while CLAIM=1 in this cycle; CLAIM=0 -> IDLE.
  - Continuing -> WAIT or BEAT per WAIT_STATES, and next beat is range-checked.
  - Next address out of range -> ERR1 instead of the next beat; beats already done stand.
- Per-beat latency: WAIT_STATES+1 cycles. An N-beat burst takes N*(WAIT_STATES+1) cycles after acceptance.
- ERR1: outputs READYOUT=0, RESP=1; next state ERR2.
- ERR2: outputs READYOUT=1, RESP=1; next state IDLE. The remainder of the burst is discarded and no write occurs.
- Word index = (ADDR-BASE_ADDR)[clog2(DEPTH)+1:2].
- CLAIM outside IDLE is ignored for acceptance; in BEAT it is used only as the INCR continue flag.
- A back-to-back request held on CLAIM is accepted in the IDLE cycle after completion, giving a minimum one-cycle gap.
- READ_DATA holds its last value outside BEAT. Its value is unspecified after write beats.

Test Plan:
- Reset, then single word write 32'hDEADBEEF @BASE+0x10, then read with WAIT_STATES=1 -> write: READYOUT reads 0 then 1. Read: READ_DATA=DEADBEEF in BEAT, 2 cycles after acceptance.
- INCR4 word read @BASE+0x0 over preloaded words 0x11,0x22,0x33,0x44 -> four BEAT pulses spaced 2 cycles, data in order, then IDLE with READYOUT=1.
- Byte write 8'hA5 @BASE+0x3 over word 0 -> read of word 0 gives 32'hA5xx_xxxx; lanes 0-2 unchanged.
- Misaligned word read @BASE+0x2 -> ERR1 (READYOUT=0, RESP=1), then ERR2 (1,1), then IDLE; no data beat.
- INCR word read from BASE+4*DEPTH-8, CLAIM held -> two good beats, then ERR1/ERR2 on the third; then INCR with CLAIM dropped after 3 beats -> exactly 3 beats.
- RSTN=0 during WAIT of an INCR8 write -> next cycle READYOUT=1, RESP=0, READ_DATA=0; target word unchanged.

Source files
------------

// File: rtl/ahb_mem_responder.sv
// rtl/ahb_mem_responder.sv - D1 single-port SRAM responder with wait states, bursts and two-cycle error response
module ahb_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] D1_ADDR,
    input  logic [31:0] D1_WRITE_DATA,
    output logic [31:0] D1_READ_DATA,
    input  logic        D1_WRITE,
    input  logic [2:0]  D1_SIZE,
    input  logic [2:0]  D1_BURST,
    output logic        D1_READYOUT,
    output logic        D1_RESP,
    input  logic        D1_CLAIM
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_BEAT = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic        r_incr;
    logic [4:0]  r_beats;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic [2:0]  w_next_state;
    logic [2:0]  w_go_state;
    logic [31:0] w_next_addr;
    logic [31:0] w_beat_addr;
    logic        w_beat_write;
    logic        w_first_ok;
    logic        w_continue;
    logic [3:0]  w_be;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    assign w_first_ok = (D1_SIZE <= 3'd2)
                     && ((D1_BURST == 3'b000) || D1_BURST[0])
                     && !((D1_SIZE == 3'd1) && D1_ADDR[0])
                     && !((D1_SIZE == 3'd2) && (D1_ADDR[1:0] != 2'b00))
                     && in_range(D1_ADDR);
    assign w_continue  = r_incr ? D1_CLAIM : (r_beats != 5'd1);
    assign w_go_state  = (WS == 4'd0) ? S_BEAT : S_WAIT;
    assign w_next_addr = r_addr + (32'd1 << r_size);

    always_comb begin
        w_next_state = r_state;
        w_beat_addr  = r_addr;
        w_beat_write = r_write;
        case (r_state)
            S_IDLE: begin
                w_beat_addr  = D1_ADDR;
                w_beat_write = D1_WRITE;
                if (D1_CLAIM) begin
                    w_next_state = w_first_ok ? w_go_state : S_ERR1;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_next_state = S_BEAT;
                end
            end
            S_BEAT: begin
                w_beat_addr = w_next_addr;
                if (!w_continue) begin
                    w_next_state = S_IDLE;
                end else if (!in_range(w_next_addr)) begin
                    w_next_state = S_ERR1;
                end else begin
                    w_next_state = w_go_state;
                end
            end
            S_ERR1:  w_next_state = S_ERR2;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be = 4'b0001 << r_addr[1:0];
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
            r_incr     <= 1'b0;
            r_beats    <= 5'd0;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_WAIT) begin
                r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt - 4'd1 : WS;
            end
            if ((r_state == S_IDLE) && D1_CLAIM) begin
                r_addr  <= D1_ADDR;
                r_write <= D1_WRITE;
                r_size  <= D1_SIZE;
                r_incr  <= (D1_BURST == 3'b001);
                case (D1_BURST)
                    3'b011:  r_beats <= 5'd4;
                    3'b101:  r_beats <= 5'd8;
                    3'b111:  r_beats <= 5'd16;
                    default: r_beats <= 5'd1;
                endcase
            end
            if (r_state == S_BEAT) begin
                r_addr  <= w_next_addr;
                r_beats <= r_beats - 5'd1;
            end
            // Fetch one cycle ahead so the word is already registered when BEAT begins.
            if ((w_next_state == S_BEAT) && !w_beat_write) begin
                r_rdata <= r_mem[word_idx(w_beat_addr)];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN && (r_state == S_BEAT) && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[word_idx(r_addr)][8*i +: 8] <= D1_WRITE_DATA[8*i +: 8];
                end
            end
        end
    end

    assign D1_READ_DATA = r_rdata;
    assign D1_READYOUT  = (r_state == S_IDLE) || (r_state == S_BEAT) || (r_state == S_ERR2);
    assign D1_RESP      = (r_state == S_ERR1) || (r_state == S_ERR2);
endmodule
